// File: rtl/garage_gate_controller.sv
// Gate-side initiator: turns lane sensor levels into single request pulses,
// waits for the matching grant and holds the barrier until the car has cleared.
module garage_gate_controller #(
    parameter int GATE_OPEN_CYCLES = 8,
    parameter int GRANT_TIMEOUT    = 4,
    parameter int TIMER_W          = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic car_at_entry,
    input  logic car_at_exit,
    input  logic open_entry_door,
    input  logic open_exit_door,
    input  logic garage_is_complete,
    output logic car_entry_request,
    output logic car_exit_request,
    output logic entry_gate_up,
    output logic exit_gate_up,
    output logic entry_denied,
    output logic grant_timeout,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_GRANT,
        S_GATE_OPEN,
        S_WAIT_CLEAR
    } state_t;

    localparam logic [TIMER_W-1:0] GRANT_LOAD = TIMER_W'(GRANT_TIMEOUT);
    localparam logic [TIMER_W-1:0] GATE_LOAD  = TIMER_W'(GATE_OPEN_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    localparam logic DIR_ENTRY = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    state_t             state, state_nxt;
    logic               dir, dir_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               denied_nxt;
    logic               timeout_nxt;
    logic               grant;
    logic               sensor;

    assign grant  = (dir == DIR_EXIT) ? open_exit_door : open_entry_door;
    assign sensor = (dir == DIR_EXIT) ? car_at_exit    : car_at_entry;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        dir_nxt     = dir;
        timer_nxt   = timer;
        denied_nxt  = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                // Exit first: serving it frees a space for a waiting entry car.
                if (car_at_exit) begin
                    dir_nxt   = DIR_EXIT;
                    state_nxt = S_REQ;
                end else if (car_at_entry && !garage_is_complete) begin
                    dir_nxt   = DIR_ENTRY;
                    state_nxt = S_REQ;
                end else if (car_at_entry) begin
                    denied_nxt = 1'b1;
                end
            end
            S_REQ: begin
                timer_nxt = GRANT_LOAD;
                state_nxt = S_WAIT_GRANT;
            end
            S_WAIT_GRANT: begin
                if (grant) begin
                    timer_nxt = GATE_LOAD;
                    state_nxt = S_GATE_OPEN;
                end else if (timer == '0) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    timer_nxt = timer - TIMER_ONE;
                end
            end
            S_GATE_OPEN: begin
                timer_nxt = (timer == '0) ? '0 : timer - TIMER_ONE;
                // The last hold cycle already samples the lane, so a car that has
                // left lets the gate drop after exactly the minimum hold time.
                if (timer <= TIMER_ONE) begin
                    state_nxt = sensor ? S_WAIT_CLEAR : S_IDLE;
                end
            end
            S_WAIT_CLEAR: begin
                if (!sensor) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_IDLE;
            dir               <= DIR_ENTRY;
            timer             <= '0;
            car_entry_request <= 1'b0;
            car_exit_request  <= 1'b0;
            entry_gate_up     <= 1'b0;
            exit_gate_up      <= 1'b0;
            entry_denied      <= 1'b0;
            grant_timeout     <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state             <= state_nxt;
            dir               <= dir_nxt;
            timer             <= timer_nxt;
            car_entry_request <= (state_nxt == S_REQ) && (dir_nxt == DIR_ENTRY);
            car_exit_request  <= (state_nxt == S_REQ) && (dir_nxt == DIR_EXIT);
            entry_gate_up     <= (state_nxt == S_GATE_OPEN || state_nxt == S_WAIT_CLEAR)
                                 && (dir_nxt == DIR_ENTRY);
            exit_gate_up      <= (state_nxt == S_GATE_OPEN || state_nxt == S_WAIT_CLEAR)
                                 && (dir_nxt == DIR_EXIT);
            entry_denied      <= denied_nxt;
            grant_timeout     <= timeout_nxt;
            busy              <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_garage_gate_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of one car being served at a time.
module tb_garage_gate_controller;

    localparam int GO = 8;
    localparam int GT = 4;

    logic clock = 1'b0;
    logic reset, car_at_entry, car_at_exit, open_entry_door, open_exit_door, garage_is_complete;
    logic car_entry_request, car_exit_request, entry_gate_up, exit_gate_up;
    logic entry_denied, grant_timeout, busy;

    always #5 clock = ~clock;

    garage_gate_controller #(
        .GATE_OPEN_CYCLES(GO),
        .GRANT_TIMEOUT(GT),
        .TIMER_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .car_at_entry(car_at_entry),
        .car_at_exit(car_at_exit),
        .open_entry_door(open_entry_door),
        .open_exit_door(open_exit_door),
        .garage_is_complete(garage_is_complete),
        .car_entry_request(car_entry_request),
        .car_exit_request(car_exit_request),
        .entry_gate_up(entry_gate_up),
        .exit_gate_up(exit_gate_up),
        .entry_denied(entry_denied),
        .grant_timeout(grant_timeout),
        .busy(busy)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: one car in service; age counts cycles since its request cycle,
    // gate_n counts barrier-up cycles so far (0 while still awaiting a grant).
    bit model_valid = 1'b0;
    bit m_active, m_lane;
    int m_age, m_gate;
    logic e_ereq, e_xreq, e_egate, e_xgate, e_denied, e_to, e_busy;

    task automatic model_step(input logic en, input logic ex, input logic oe,
                              input logic ox, input logic full, input logic rst);
        bit to, dn, g, s;
        to = 1'b0;
        dn = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_lane   = 1'b0;
            m_age    = 0;
            m_gate   = 0;
        end else if (!m_active) begin
            if (ex || (en && !full)) begin
                m_active = 1'b1;
                m_lane   = ex;
                m_age    = 0;
                m_gate   = 0;
            end else if (en) begin
                dn = 1'b1;
            end
        end else if (m_gate == 0) begin
            g = m_lane ? ox : oe;
            if (m_age >= 1 && g) m_gate = 1;
            else if (m_age >= GT + 1) begin
                m_active = 1'b0;
                to       = 1'b1;
            end else m_age++;
        end else begin
            s = m_lane ? ex : en;
            if (m_gate >= GO && !s) m_active = 1'b0;
            else m_gate++;
        end
        e_ereq   = m_active && m_gate == 0 && m_age == 0 && !m_lane;
        e_xreq   = m_active && m_gate == 0 && m_age == 0 && m_lane;
        e_egate  = m_active && m_gate > 0 && !m_lane;
        e_xgate  = m_active && m_gate > 0 && m_lane;
        e_denied = dn;
        e_to     = to;
        e_busy   = m_active;
        model_valid = 1'b1;
    endtask

    // Apply one cycle of inputs (sampled at the next rising edge) and advance the model.
    task automatic cyc(input logic en, input logic ex, input logic oe,
                       input logic ox, input logic full, input logic rst);
        @(negedge clock);
        #1;
        car_at_entry       = en;
        car_at_exit        = ex;
        open_entry_door    = oe;
        open_exit_door     = ox;
        garage_is_complete = full;
        reset              = rst;
        model_step(en, ex, oe, ox, full, rst);
    endtask

    task automatic peek();
        @(posedge clock);
        #1;
    endtask

    int cnt [7];
    int cyc_n = 0;
    int last_exit_gate = 0, last_exit_req = 0, last_entry_req = 0;
    int prev_to = 0;
    bit gap_en = 1'b0;

    always @(negedge clock) begin
        cyc_n++;
        if (model_valid) begin
            check("car_entry_request", car_entry_request, e_ereq);
            check("car_exit_request", car_exit_request, e_xreq);
            check("entry_gate_up", entry_gate_up, e_egate);
            check("exit_gate_up", exit_gate_up, e_xgate);
            check("entry_denied", entry_denied, e_denied);
            check("grant_timeout", grant_timeout, e_to);
            check("busy", busy, e_busy);
            check("req_exclusive", car_entry_request & car_exit_request, 1'b0);
            cnt[0] += int'(car_entry_request);
            cnt[1] += int'(car_exit_request);
            cnt[2] += int'(entry_gate_up);
            cnt[3] += int'(exit_gate_up);
            cnt[4] += int'(grant_timeout);
            cnt[5] += int'(entry_denied);
            cnt[6] += int'(busy);
            if (car_exit_request === 1'b1) last_exit_req = cyc_n;
            if (car_entry_request === 1'b1) last_entry_req = cyc_n;
            if (exit_gate_up === 1'b1) last_exit_gate = cyc_n;
            if (!gap_en) prev_to = 0;
            else if (grant_timeout === 1'b1) begin
                if (prev_to > 0) check("timeout_period", cyc_n - prev_to, 7);
                prev_to = cyc_n;
            end
        end
    end

    int snap [7];
    logic r_en, r_ex, r_full;

    initial begin
        foreach (cnt[i]) cnt[i] = 0;
        reset = 1'b1;
        {car_at_entry, car_at_exit, open_entry_door, open_exit_door, garage_is_complete} = '0;

        // Reset state.
        cyc(0, 0, 0, 0, 0, 1);
        peek();
        check("reset_outputs", {car_entry_request, car_exit_request, entry_gate_up,
              exit_gate_up, entry_denied, grant_timeout, busy}, 7'b0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);

        // Entry, normal: grant one cycle after the request, car leaves early.
        snap = cnt;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 0);
        check("normal_entry_requests", cnt[0] - snap[0], 1);
        check("normal_entry_gate_cycles", cnt[2] - snap[2], 8);
        check("normal_busy_cycles", cnt[6] - snap[6], 10);

        // Entry, garage full for 10 cycles, then space frees up.
        snap = cnt;
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        peek();
        check("full_release_request", car_entry_request, 1'b1);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 0);
        check("full_denied_cycles", cnt[5] - snap[5], 10);
        check("full_entry_requests", cnt[0] - snap[0], 1);

        // Simultaneous arrival with prompt grants on both lanes.
        snap = cnt;
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 0, 0);
        check("simul_exit_requests", cnt[1] - snap[1], 1);
        check("simul_entry_requests", cnt[0] - snap[0], 1);
        check("simul_exit_before_entry", last_exit_req < last_entry_req, 1'b1);
        check("simul_entry_after_exit_gate", last_entry_req > last_exit_gate, 1'b1);

        // Grant timeout: exit car held, never granted.
        snap = cnt;
        gap_en = 1'b1;
        for (int i = 0; i < 30; i++) cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
        gap_en = 1'b0;
        check("timeout_pulses", cnt[4] - snap[4], 5);
        check("timeout_exit_requests", cnt[1] - snap[1], 5);
        check("timeout_no_gate", cnt[3] - snap[3], 0);

        // Car lingers: sensor high through 20 gate cycles.
        snap = cnt;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 19; i++) cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        check("linger_gate_cycles", cnt[2] - snap[2], 20);
        check("linger_requests", cnt[0] - snap[0], 1);

        // Reset while the exit gate is open.
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        peek();
        check("midgate_reset_outputs", {car_entry_request, car_exit_request, entry_gate_up,
              exit_gate_up, entry_denied, grant_timeout, busy}, 7'b0);
        cyc(0, 1, 0, 0, 0, 0);
        peek();
        check("post_reset_request", car_exit_request, 1'b1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0);

        // Random traffic with persistent sensors and sporadic grants/resets.
        r_en = 1'b0;
        r_ex = 1'b0;
        r_full = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) r_en = ~r_en;
            if ($urandom_range(9) == 0) r_ex = ~r_ex;
            if ($urandom_range(15) == 0) r_full = ~r_full;
            cyc(r_en, r_ex, $urandom_range(3) == 0, $urandom_range(3) == 0, r_full,
                $urandom_range(299) == 0);
        end
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0);
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
